// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Purpose  : Multi-lane fetch-to-decode queue that also marks instructions
//            sitting under a short-forward-branch shadow.
// Revision : 1.0
// ============================================================================
module decode_queue #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 8,
    parameter int SHADOW_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_valid,
    input  logic [32*WIDTH-1:0]       in_instr,
    input  logic [32*WIDTH-1:0]       in_pc,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_valid,
    output logic [32*WIDTH-1:0]       out_instr,
    output logic [32*WIDTH-1:0]       out_pc,
    output logic [WIDTH-1:0]          out_shadowed,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_SW = $clog2(SHADOW_MAX + 1);

    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic [c_SW-1:0] r_shdw;

    logic [31:0]     r_instr_mem [DEPTH];
    logic [31:0]     r_pc_mem    [DEPTH];

    logic [c_CW-1:0] w_enq_n;
    logic [c_CW-1:0] w_deq_n;
    logic            w_run_stop;
    logic [c_SW-1:0] w_run;
    logic [c_SW-1:0] w_shdw_next;

    logic [WIDTH-1:0] w_is_sfb;
    logic [WIDTH-1:0] w_is_shadowable;
    logic [c_SW-1:0]  w_sfb_len [WIDTH];

    assign count    = r_count;
    assign in_ready = (c_CW'(DEPTH) - r_count) >= c_CW'(WIDTH);

    // Only the unbroken run of valid lanes starting at lane 0 is accepted.
    always_comb begin
        w_enq_n    = '0;
        w_run_stop = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!in_valid[i]) begin
                w_run_stop = 1'b1;
            end else if (!w_run_stop) begin
                w_enq_n = w_enq_n + c_CW'(1);
            end
        end
        if (!in_ready) begin
            w_enq_n = '0;
        end
    end

    always_comb begin
        w_deq_n = '0;
        if (out_ready) begin
            w_deq_n = (r_count > c_CW'(WIDTH)) ? c_CW'(WIDTH) : r_count;
        end
    end

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_lane
            logic [c_AW-1:0] w_idx;
            logic [12:0]     w_bimm;

            assign w_idx                = r_head + c_AW'(g);
            assign out_valid[g]         = r_count > c_CW'(g);
            assign out_instr[32*g +: 32] = r_instr_mem[w_idx];
            assign out_pc[32*g +: 32]    = r_pc_mem[w_idx];

            assign w_bimm = {out_instr[32*g+31], out_instr[32*g+7],
                             out_instr[32*g+25 +: 6], out_instr[32*g+8 +: 4], 1'b0};

            assign w_is_sfb[g] = (out_instr[32*g +: 7] == 7'b1100011)
                              && (out_instr[32*g+12 +: 3] != 3'b010)
                              && (out_instr[32*g+12 +: 3] != 3'b011)
                              && !out_instr[32*g+31]
                              && (w_bimm != 13'd0)
                              && ({19'd0, w_bimm} <= 32'(4 * SHADOW_MAX));

            // A 2-byte offset yields a zero-length shadow rather than wrapping.
            assign w_sfb_len[g] = (w_bimm[12:2] == 11'd0) ? '0
                                : c_SW'(w_bimm[12:2] - 11'd1);

            assign w_is_shadowable[g] = (out_instr[32*g +: 7] == 7'b0110111)
                                     || (out_instr[32*g +: 7] == 7'b0010011)
                                     || ((out_instr[32*g +: 7] == 7'b0110011)
                                         && ((out_instr[32*g+25 +: 7] == 7'b0000000)
                                          || (out_instr[32*g+25 +: 7] == 7'b0100000)));
        end
    endgenerate

    // Walk lanes oldest-first, carrying the remaining shadow length across them.
    always_comb begin
        w_run        = r_shdw;
        out_shadowed = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (out_valid[i]) begin
                if (w_run != '0) begin
                    if (w_is_shadowable[i]) begin
                        out_shadowed[i] = 1'b1;
                        w_run           = w_run - c_SW'(1);
                    end else begin
                        w_run = '0;
                    end
                end
                if (w_is_sfb[i]) begin
                    w_run = w_sfb_len[i];
                end
            end
        end
        w_shdw_next = w_run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_shdw  <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_shdw  <= '0;
        end else begin
            r_tail  <= r_tail + c_AW'(w_enq_n);
            r_head  <= r_head + c_AW'(w_deq_n);
            r_count <= r_count + w_enq_n - w_deq_n;
            if (out_ready) begin
                r_shdw <= w_shdw_next;
            end
        end
    end

    // Storage is never reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (c_CW'(i) < w_enq_n) begin
                    r_instr_mem[r_tail + c_AW'(i)] <= in_instr[32*i +: 32];
                    r_pc_mem[r_tail + c_AW'(i)]    <= in_pc[32*i +: 32];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 The module SHALL take parameter WIDTH, default 2, giving the number of decode lanes per cycle.
REQ-002 The module SHALL take parameter DEPTH, default 8, giving the entry count; DEPTH SHALL be a power of two and at least 2*WIDTH.
REQ-003 The module SHALL take parameter SHADOW_MAX, default 4, giving the maximum forward-branch shadow length in instructions.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  WIDTH  per-lane fetch valid.
- in_instr  in  32*WIDTH  fetch instructions; lane i at [32i+31:32i].
- in_pc  in  32*WIDTH  fetch PCs.
- in_ready  out  1  queue can accept a full packet.
- flush  in  1  discard all contents and shadow state.
- out_valid  out  WIDTH  per-lane decode valid.
- out_instr  out  32*WIDTH  oldest instructions; lane 0 is the oldest.
- out_pc  out  32*WIDTH  matching PCs.
- out_shadowed  out  WIDTH  lane sits under a short-forward-branch shadow.
- out_ready  in  1  consumer takes all valid output lanes.
- count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-005 Enqueue SHALL occur when in_ready=1 and any in_valid bit is 1.
REQ-006 On enqueue, only the contiguous run of set in_valid bits starting at lane 0 SHALL be written; lanes after the first clear bit SHALL be dropped.
REQ-007 in_ready SHALL equal (DEPTH-count >= WIDTH), using the registered count; same-cycle dequeue SHALL NOT be credited.
REQ-008 out_valid[i] SHALL equal (count > i), and out lane i SHALL present entry head+i modulo DEPTH.
REQ-009 Dequeue SHALL occur when out_ready=1; it SHALL remove popcount(out_valid) entries.
REQ-010 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-011 count SHALL update by +enq_n-deq_n in the same edge when enqueue and dequeue coincide.
REQ-012 An enqueued instruction SHALL become visible on the outputs the cycle after its enqueue edge (latency 1).
REQ-013 An instruction is a short forward branch (SFB) when:
- opcode is 1100011;
- funct3 is not 010 or 011;
- instr[31]=0;
- its B-immediate is non-zero and at most 4*SHADOW_MAX.
REQ-014 An instruction is shadowable when it is one of:
- LUI;
- OP-IMM (0010011);
- OP (0110011) with funct7 of 0000000 or 0100000.
REQ-015 A registered shadow counter shdw, $clog2(SHADOW_MAX+1) bits wide, SHALL track remaining shadow length; lanes SHALL be evaluated in order 0..WIDTH-1 with a running value starting at shdw.
REQ-016 Per valid lane, if the running value is >0 and the lane is shadowable, out_shadowed SHALL be 1 and the running value SHALL decrement by 1.
REQ-017 Per valid lane, if the running value is >0 and the lane is not shadowable, out_shadowed SHALL be 0 and the running value SHALL clear to 0 (shadow cancelled).
REQ-018 Per valid lane, if the lane is an SFB, the running value SHALL then load imm/4-1; an SFB itself SHALL never be marked shadowed.
REQ-019 shdw SHALL take the final running value only on a dequeue cycle; otherwise it SHALL hold.
REQ-020 out_shadowed SHALL be 0 on invalid lanes.
REQ-021 flush SHALL clear head, tail, count and shdw at the next edge, overriding any same-cycle enqueue or dequeue.
REQ-022 With count=0, a same-cycle enqueue SHALL NOT bypass to the outputs.

Reset
REQ-023 While rst_n=0, head, tail, count and shdw SHALL be 0.
REQ-024 While rst_n=0, out_valid and out_shadowed SHALL be 0 and in_ready SHALL be 1.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately; storage contents need not be cleared.

Verification
REQ-026 The bench SHALL cover fill: WIDTH=2, DEPTH=8, four packets of two, out_ready=0 -> count=8, in_ready=0 after the 4th edge; a 5th packet is ignored.
REQ-027 The bench SHALL cover partial packet: in_valid=2'b10 -> nothing enqueued; in_valid=2'b01 -> count +1.
REQ-028 The bench SHALL cover a simultaneous event: count=6, enqueue 2 and dequeue 2 in one cycle -> count stays 6 and head advances by 2 with wrap.
REQ-029 The bench SHALL cover the shadow case: BEQ with imm=+12 followed by ADDI, ADD, ADDI -> out_shadowed = 0,1,1,0 and shdw=0 afterwards.
REQ-030 The bench SHALL cover shadow cancel: BNE with imm=+16, then LW, then ADDI -> LW unshadowed, ADDI unshadowed, shdw=0.
REQ-031 The bench SHALL cover flush and reset: flush with count=5 and a simultaneous enqueue -> count=0 next cycle; rst_n low mid-stream -> out_valid=0 immediately.
